snitch_icache_lookup_arb: RTL and testbench
===========================================

Name: snitch_icache_lookup_arb

Overview:
- Shares one serial icache lookup between NR_PORTS L0 fetch requesters.
- Round-robin arbitrates requests onto the lookup request port with one-hot IDs.
- Demultiplexes lookup responses: hits go back to the issuing port, misses go to a single miss port feeding the refill handler.
- Sequences flushes: stop accepting requests, drain in-flight lookups, issue the lookup flush, then acknowledge.

Parameters:
- CFG, '0, snitch_icache_pkg::config_t. FETCH_AW, LINE_WIDTH, SET_ALIGN and ID_WIDTH_REQ come from it. ID_WIDTH_REQ must equal NR_PORTS.
- NR_PORTS, 2, number of requesters (>=1).
- MAX_OUTSTANDING, 4, maximum lookups accepted by the lookup but not yet retired.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_addr_i  in  NR_PORTS x FETCH_AW  per-port fetch address
- req_valid_i  in  NR_PORTS  per-port request valid
- req_ready_o  out  NR_PORTS  per-port request ready
- rsp_data_o  out  LINE_WIDTH  hit line, shared by all ports
- rsp_error_o  out  1  hit error, shared
- rsp_valid_o  out  NR_PORTS  per-port response valid
- rsp_ready_i  in  NR_PORTS  per-port response ready
- lk_addr_o  out  FETCH_AW  lookup request address
- lk_id_o  out  ID_WIDTH_REQ  lookup request ID, one-hot port
- lk_valid_o  out  1  lookup request valid
- lk_ready_i  in  1  lookup request ready
- lk_addr_i, lk_id_i, lk_set_i, lk_hit_i, lk_data_i, lk_error_i  in  lookup response fields
- lk_valid_i  in  1  lookup response valid
- lk_ready_o  out  1  lookup response ready
- miss_addr_o  out  FETCH_AW  missed address
- miss_id_o  out  ID_WIDTH_REQ  missed ID
- miss_set_o  out  SET_ALIGN  missed set
- miss_valid_o  out  1  miss valid
- miss_ready_i  in  1  miss ready
- lk_flush_valid_o  out  1  lookup flush request
- lk_flush_ready_i  in  1  lookup flush ready
- flush_valid_i  in  1  external flush request
- flush_ready_o  out  1  external flush acknowledge

Behaviour:
- Reset values:
  - rr pointer = 0, grant lock clear, outstanding = 0, FSM = IDLE.
  - All valid/ready outputs are 0 at reset, except req_ready_o, which follows lk_ready_i once in IDLE.
- Arbitration:
  - Round-robin starting at the rr pointer. lk_addr_o is the winning port's address; lk_id_o = 1<<winner.
  - If lk_valid_o is asserted without lk_ready_i, the grant is locked to that port until the handshake. addr/id must stay stable.
  - req_ready_o[winner] = lk_ready_i; all other ports see ready 0.
  - On handshake, the rr pointer becomes winner+1, wrapping at NR_PORTS.
  - lk_valid_o is gated to 0 when outstanding == MAX_OUTSTANDING or FSM != IDLE.
- Outstanding counter:
  - Width $clog2(MAX_OUTSTANDING+1).
  - +1 on request handshake, -1 on response retire; both in one cycle means no change.
  - Never overflows or underflows. Underflow is an assertion failure.
- Response routing (combinational, zero latency):
  - On hit: rsp_valid_o = lk_id_i & {NR_PORTS{lk_valid_i}}, lk_ready_o = |(lk_id_i & rsp_ready_i).
  - On miss: miss_* = lk_* and miss_valid_o = lk_valid_i; lk_ready_o = miss_ready_i.
  - A response retires on the lk_valid_i && lk_ready_o handshake.
  - An error hit is routed like a hit.
- Flush FSM:
  - IDLE -> DRAIN when flush_valid_i. Requests are blocked from the next cycle; a handshake in the same cycle still counts.
  - DRAIN -> FLUSH when outstanding == 0 (may be in the same cycle as entry).
  - FLUSH: assert lk_flush_valid_o; on lk_flush_ready_i go to DONE.
  - DONE: flush_ready_o = 1 for one cycle, then IDLE.
  - flush_valid_i is ignored outside IDLE.
  - Responses keep retiring during DRAIN.
- Reset mid-flush returns the FSM to IDLE and clears the counter. The lookup resets itself independently.
- With NR_PORTS == 1 the rr pointer is constant 0.

Decomposition:
- Shared package snitch_icache_pkg: add flush FSM state enum (IDLE, DRAIN, FLUSH, DONE) and a lookup-response struct (addr, id, set, hit, data, error).
- Sub-module: rr_arb_tree from common_cells with LockIn=1, ExtPrio=0. No custom sub-module.

Test Plan:
- NR_PORTS=2, both ports request 0x100/0x200 continuously with lk_ready_i=1 -> grants alternate 0,1,0,1; lk_id_o alternates 2'b01/2'b10.
- Port1 requests, lk_ready_i low for 3 cycles while port0 also requests -> lk_id_o stays 2'b10 with stable addr until the handshake; port0 is granted next.
- Response id=2'b10, hit=1, rsp_ready_i=2'b00 for 2 cycles -> rsp_valid_o=2'b10 held, lk_ready_o=0; lk_ready_o=1 once rsp_ready_i[1]=1.
- Response hit=0, addr 0x340, miss_ready_i=1 -> miss_valid_o=1, miss_addr_o=0x340, no rsp_valid_o, outstanding decrements.
- Issue 4 requests with no responses, MAX_OUTSTANDING=4 -> lk_valid_o=0 and req_ready_o=0 until one response retires.
- 2 outstanding, flush_valid_i pulse -> no new grants; lk_flush_valid_o asserts the cycle after the second retire; flush_ready_o pulses 1 cycle after lk_flush_ready_i; granting resumes in IDLE.

Source files
------------

// File: rtl/snitch_icache_pkg.sv
// Shared icache types: configuration record, flush sequencer states and the lookup response record.
package snitch_icache_pkg;

  typedef struct packed {
    logic [31:0] FETCH_AW;
    logic [31:0] LINE_WIDTH;
    logic [31:0] SET_ALIGN;
    logic [31:0] ID_WIDTH_REQ;
  } config_t;

  // An all-zero configuration has no usable widths, so a small working default is provided.
  localparam config_t DefaultCfg = '{
    FETCH_AW:     32'd32,
    LINE_WIDTH:   32'd64,
    SET_ALIGN:    32'd2,
    ID_WIDTH_REQ: 32'd2
  };

  typedef enum logic [1:0] {
    FLUSH_IDLE  = 2'd0,
    FLUSH_DRAIN = 2'd1,
    FLUSH_FLUSH = 2'd2,
    FLUSH_DONE  = 2'd3
  } flush_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  id;
    logic [1:0]  set;
    logic        hit;
    logic [63:0] data;
    logic        error;
  } lookup_rsp_t;

endpackage

// File: rtl/rr_arb_tree.sv
// Round-robin arbiter with optional grant lock: a request that is offered but not yet granted keeps the grant.
module rr_arb_tree #(
  parameter int unsigned NumIn     = 2,
  parameter int unsigned DataWidth = 32,
  parameter bit          ExtPrio   = 1'b0,
  parameter bit          LockIn    = 1'b0,
  localparam int unsigned IdxWidth = (NumIn > 1) ? $clog2(NumIn) : 1
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                flush_i,
  input  logic [NumIn-1:0]                    req_i,
  output logic [NumIn-1:0]                    gnt_o,
  input  logic [NumIn-1:0][DataWidth-1:0]     data_i,
  output logic                                req_o,
  input  logic                                gnt_i,
  output logic [DataWidth-1:0]                data_o,
  output logic [IdxWidth-1:0]                 idx_o
);

  logic [IdxWidth-1:0] r_rr;
  logic [IdxWidth-1:0] r_lock_idx;
  logic                r_lock;
  logic                w_any_hi;
  logic [IdxWidth-1:0] w_idx_hi;
  logic [IdxWidth-1:0] w_idx_lo;
  logic                w_locked;

  // Lowest requester at or above the pointer, else the lowest requester overall.
  always_comb begin
    w_any_hi = 1'b0;
    w_idx_hi = '0;
    w_idx_lo = '0;
    for (int j = int'(NumIn) - 1; j >= 0; j--) begin
      w_idx_lo = req_i[j] ? IdxWidth'(j) : w_idx_lo;
      w_any_hi = w_any_hi | (req_i[j] & (IdxWidth'(j) >= r_rr));
      w_idx_hi = (req_i[j] && (IdxWidth'(j) >= r_rr)) ? IdxWidth'(j) : w_idx_hi;
    end
  end

  assign w_locked = LockIn && r_lock;
  assign idx_o    = w_locked ? r_lock_idx : (w_any_hi ? w_idx_hi : w_idx_lo);
  assign req_o    = w_locked ? req_i[r_lock_idx] : (|req_i);
  assign data_o   = data_i[idx_o];
  assign gnt_o    = (req_o && gnt_i) ? (NumIn'(1) << idx_o) : '0;

  // Pointer advances past the winner on a handshake; lock holds a stalled offer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr       <= '0;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
    end else if (flush_i) begin
      r_rr       <= '0;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
    end else begin
      r_lock     <= LockIn && req_o && !gnt_i;
      r_lock_idx <= idx_o;
      if (req_o && gnt_i) begin
        r_rr <= (idx_o == IdxWidth'(NumIn - 1)) ? IdxWidth'(0) : idx_o + IdxWidth'(1);
      end
    end
  end

endmodule

// File: rtl/snitch_icache_lookup_arb_chk.sv
// Guards the in-flight lookup counter against wrapping in either direction.
module snitch_icache_lookup_arb_chk #(
  parameter int unsigned CNT_W   = 3,
  parameter int unsigned MAX_CNT = 4
) (
  input logic             i_clk,
  input logic             i_rst_n,
  input logic [CNT_W-1:0] i_cnt,
  input logic             i_inc,
  input logic             i_dec
);

  // Retiring with nothing in flight means the lookup answered a request it never took.
  always @(posedge i_clk) begin
    if (i_rst_n) begin
      assert (!(i_dec && !i_inc && i_cnt == CNT_W'(0)))
        else $error("outstanding counter underflow");
      assert (!(i_inc && !i_dec && i_cnt == CNT_W'(MAX_CNT)))
        else $error("outstanding counter overflow");
    end
  end

endmodule

// File: rtl/snitch_icache_lookup_arb.sv
// Shares one icache lookup between several fetch ports: round-robin request side,
// hit/miss response demux, and a drain-then-flush sequencer.
module snitch_icache_lookup_arb
  import snitch_icache_pkg::*;
#(
  parameter config_t     CFG             = DefaultCfg,
  parameter int unsigned NR_PORTS        = 2,
  parameter int unsigned MAX_OUTSTANDING = 4,
  localparam int unsigned FETCH_AW     = CFG.FETCH_AW,
  localparam int unsigned LINE_WIDTH   = CFG.LINE_WIDTH,
  localparam int unsigned SET_ALIGN    = CFG.SET_ALIGN,
  localparam int unsigned ID_WIDTH_REQ = CFG.ID_WIDTH_REQ
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NR_PORTS-1:0][FETCH_AW-1:0]  req_addr_i,
  input  logic [NR_PORTS-1:0]                req_valid_i,
  output logic [NR_PORTS-1:0]                req_ready_o,
  output logic [LINE_WIDTH-1:0]              rsp_data_o,
  output logic                               rsp_error_o,
  output logic [NR_PORTS-1:0]                rsp_valid_o,
  input  logic [NR_PORTS-1:0]                rsp_ready_i,
  output logic [FETCH_AW-1:0]                lk_addr_o,
  output logic [ID_WIDTH_REQ-1:0]            lk_id_o,
  output logic                               lk_valid_o,
  input  logic                               lk_ready_i,
  input  logic [FETCH_AW-1:0]                lk_addr_i,
  input  logic [ID_WIDTH_REQ-1:0]            lk_id_i,
  input  logic [SET_ALIGN-1:0]               lk_set_i,
  input  logic                               lk_hit_i,
  input  logic [LINE_WIDTH-1:0]              lk_data_i,
  input  logic                               lk_error_i,
  input  logic                               lk_valid_i,
  output logic                               lk_ready_o,
  output logic [FETCH_AW-1:0]                miss_addr_o,
  output logic [ID_WIDTH_REQ-1:0]            miss_id_o,
  output logic [SET_ALIGN-1:0]               miss_set_o,
  output logic                               miss_valid_o,
  input  logic                               miss_ready_i,
  output logic                               lk_flush_valid_o,
  input  logic                               lk_flush_ready_i,
  input  logic                               flush_valid_i,
  output logic                               flush_ready_o
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned IDX_W = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;

  flush_state_e        r_state;
  flush_state_e        w_state_next;
  logic [CNT_W-1:0]    r_outstanding;
  logic [CNT_W-1:0]    w_outstanding_next;
  logic                w_accept;
  logic [NR_PORTS-1:0] w_arb_req;
  logic [IDX_W-1:0]    w_arb_idx;
  logic                w_req_hs;
  logic                w_rsp_hs;

  // New lookups only while idle and below the in-flight limit.
  assign w_accept  = (r_state == FLUSH_IDLE) && (r_outstanding != CNT_W'(MAX_OUTSTANDING));
  assign w_arb_req = req_valid_i & {NR_PORTS{w_accept}};

  rr_arb_tree #(
    .NumIn     (NR_PORTS),
    .DataWidth (FETCH_AW),
    .ExtPrio   (1'b0),
    .LockIn    (1'b1)
  ) i_rr_arb_tree (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (1'b0),
    .req_i   (w_arb_req),
    .gnt_o   (req_ready_o),
    .data_i  (req_addr_i),
    .req_o   (lk_valid_o),
    .gnt_i   (lk_ready_i),
    .data_o  (lk_addr_o),
    .idx_o   (w_arb_idx)
  );

  assign lk_id_o = ID_WIDTH_REQ'(1) << w_arb_idx;

  // Hits go straight back to the port named by the one-hot ID; misses go to the refill side.
  assign rsp_data_o   = lk_data_i;
  assign rsp_error_o  = lk_error_i;
  assign rsp_valid_o  = lk_hit_i ? (lk_id_i & {NR_PORTS{lk_valid_i}}) : {NR_PORTS{1'b0}};
  assign miss_addr_o  = lk_addr_i;
  assign miss_id_o    = lk_id_i;
  assign miss_set_o   = lk_set_i;
  assign miss_valid_o = lk_valid_i & ~lk_hit_i;
  assign lk_ready_o   = lk_hit_i ? (|(lk_id_i & rsp_ready_i)) : miss_ready_i;

  assign w_req_hs = lk_valid_o & lk_ready_i;
  assign w_rsp_hs = lk_valid_i & lk_ready_o;

  // In-flight count: issue adds one, retire removes one, both together cancel.
  always_comb begin
    w_outstanding_next = r_outstanding;
    if (w_req_hs && !w_rsp_hs && (r_outstanding != CNT_W'(MAX_OUTSTANDING))) begin
      w_outstanding_next = r_outstanding + CNT_W'(1);
    end else if (!w_req_hs && w_rsp_hs && (r_outstanding != CNT_W'(0))) begin
      w_outstanding_next = r_outstanding - CNT_W'(1);
    end else begin
      w_outstanding_next = r_outstanding;
    end
  end

  // Flush sequencing looks at the post-update count so an empty pipe moves on without a bubble.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FLUSH_IDLE: begin
        if (flush_valid_i) begin
          w_state_next = (w_outstanding_next == CNT_W'(0)) ? FLUSH_FLUSH : FLUSH_DRAIN;
        end else begin
          w_state_next = FLUSH_IDLE;
        end
      end
      FLUSH_DRAIN: begin
        if (w_outstanding_next == CNT_W'(0)) begin
          w_state_next = FLUSH_FLUSH;
        end else begin
          w_state_next = FLUSH_DRAIN;
        end
      end
      FLUSH_FLUSH: begin
        if (lk_flush_ready_i) begin
          w_state_next = FLUSH_DONE;
        end else begin
          w_state_next = FLUSH_FLUSH;
        end
      end
      FLUSH_DONE: w_state_next = FLUSH_IDLE;
      default:    w_state_next = FLUSH_IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= FLUSH_IDLE;
      r_outstanding <= CNT_W'(0);
    end else begin
      r_state       <= w_state_next;
      r_outstanding <= w_outstanding_next;
    end
  end

  assign lk_flush_valid_o = (r_state == FLUSH_FLUSH);
  assign flush_ready_o    = (r_state == FLUSH_DONE);

  snitch_icache_lookup_arb_chk #(
    .CNT_W   (CNT_W),
    .MAX_CNT (MAX_OUTSTANDING)
  ) i_chk (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_cnt   (r_outstanding),
    .i_inc   (w_req_hs),
    .i_dec   (w_rsp_hs)
  );

endmodule

// File: tb/tb_snitch_icache_lookup_arb.sv
// Directed and randomized bench for the lookup arbiter, checked against a queue-based model of in-flight lookups.
module tb_snitch_icache_lookup_arb;

  localparam int NP      = 2;
  localparam int MAX_OUT = 4;
  localparam int PH_IDLE = 0;
  localparam int PH_DRAIN = 1;
  localparam int PH_FLUSH = 2;
  localparam int PH_DONE = 3;
  localparam snitch_icache_pkg::config_t TB_CFG = '{
    FETCH_AW: 32'd32, LINE_WIDTH: 32'd64, SET_ALIGN: 32'd2, ID_WIDTH_REQ: 32'd2
  };

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NP-1:0][31:0] req_addr;
  logic [NP-1:0]     req_valid;
  logic [NP-1:0]     req_ready;
  logic [63:0]       rsp_data;
  logic              rsp_error;
  logic [NP-1:0]     rsp_valid;
  logic [NP-1:0]     rsp_ready;
  logic [31:0]       lk_addr_o;
  logic [NP-1:0]     lk_id_o;
  logic              lk_valid_o;
  logic              lk_ready_i;
  logic [31:0]       lk_addr_i;
  logic [NP-1:0]     lk_id_i;
  logic [1:0]        lk_set_i;
  logic              lk_hit_i;
  logic [63:0]       lk_data_i;
  logic              lk_error_i;
  logic              lk_valid_i;
  logic              lk_ready_o;
  logic [31:0]       miss_addr;
  logic [NP-1:0]     miss_id;
  logic [1:0]        miss_set;
  logic              miss_valid;
  logic              miss_ready;
  logic              lk_flush_valid;
  logic              lk_flush_ready;
  logic              flush_valid;
  logic              flush_ready;

  int n_vec = 0;
  int n_err = 0;

  // Model: ports of accepted-but-unretired lookups in issue order, plus pointer/lock/flush phase.
  int inflight[$];
  int m_rr;
  int m_lock;
  int m_phase;
  int last_gnt;
  bit last_rsp;

  always #5 clk = ~clk;

  snitch_icache_lookup_arb #(
    .CFG             (TB_CFG),
    .NR_PORTS        (NP),
    .MAX_OUTSTANDING (MAX_OUT)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .req_addr_i       (req_addr),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .rsp_data_o       (rsp_data),
    .rsp_error_o      (rsp_error),
    .rsp_valid_o      (rsp_valid),
    .rsp_ready_i      (rsp_ready),
    .lk_addr_o        (lk_addr_o),
    .lk_id_o          (lk_id_o),
    .lk_valid_o       (lk_valid_o),
    .lk_ready_i       (lk_ready_i),
    .lk_addr_i        (lk_addr_i),
    .lk_id_i          (lk_id_i),
    .lk_set_i         (lk_set_i),
    .lk_hit_i         (lk_hit_i),
    .lk_data_i        (lk_data_i),
    .lk_error_i       (lk_error_i),
    .lk_valid_i       (lk_valid_i),
    .lk_ready_o       (lk_ready_o),
    .miss_addr_o      (miss_addr),
    .miss_id_o        (miss_id),
    .miss_set_o       (miss_set),
    .miss_valid_o     (miss_valid),
    .miss_ready_i     (miss_ready),
    .lk_flush_valid_o (lk_flush_valid),
    .lk_flush_ready_i (lk_flush_ready),
    .flush_valid_i    (flush_valid),
    .flush_ready_o    (flush_ready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    inflight.delete();
    m_rr = 0;
    m_lock = -1;
    m_phase = PH_IDLE;
    last_gnt = -1;
    last_rsp = 1'b0;
  endtask

  function automatic int pick_winner();
    if (m_lock >= 0 && req_valid[m_lock]) return m_lock;
    for (int k = 0; k < NP; k++) begin
      if (req_valid[(m_rr + k) % NP]) return (m_rr + k) % NP;
    end
    return -1;
  endfunction

  task automatic zero_inputs();
    req_valid = '0; req_addr = '0; rsp_ready = '0; lk_ready_i = 1'b0;
    lk_addr_i = '0; lk_id_i = '0; lk_set_i = '0; lk_hit_i = 1'b0; lk_data_i = '0;
    lk_error_i = 1'b0; lk_valid_i = 1'b0; miss_ready = 1'b0; lk_flush_ready = 1'b0;
    flush_valid = 1'b0;
  endtask

  task automatic drive_head_rsp(input logic hit, input logic [31:0] addr);
    lk_valid_i = 1'b1;
    lk_hit_i   = hit;
    lk_id_i    = 2'(1) << inflight[0];
    lk_addr_i  = addr;
    lk_set_i   = 2'($urandom);
    lk_data_i  = {$urandom, $urandom};
    lk_error_i = 1'($urandom);
  endtask

  // One cycle: check outputs mid-cycle against the model, then advance the model at the edge.
  task automatic step();
    int w;
    logic acc, v, rdy_exp, req_hs, rsp_hs;
    logic [NP-1:0] id_exp;
    @(negedge clk);
    if (!rst_n) model_reset();
    acc = (m_phase == PH_IDLE) && (inflight.size() < MAX_OUT);
    w = pick_winner();
    v = acc && (w >= 0);
    chk("lk_valid", 64'(lk_valid_o), 64'(v));
    if (v) begin
      id_exp = 2'(1) << w;
      chk("lk_addr", 64'(lk_addr_o), 64'(req_addr[w]));
      chk("lk_id", 64'(lk_id_o), 64'(id_exp));
      chk("req_ready", 64'(req_ready), 64'(lk_ready_i ? id_exp : 2'b00));
    end else begin
      chk("req_ready_idle", 64'(req_ready), 64'(0));
    end
    rdy_exp = lk_hit_i ? (|(lk_id_i & rsp_ready)) : miss_ready;
    chk("lk_ready_o", 64'(lk_ready_o), 64'(rdy_exp));
    chk("rsp_valid", 64'(rsp_valid), 64'((lk_valid_i && lk_hit_i) ? lk_id_i : 2'b00));
    chk("miss_valid", 64'(miss_valid), 64'(lk_valid_i && !lk_hit_i));
    if (lk_valid_i && !lk_hit_i) begin
      chk("miss_addr", 64'(miss_addr), 64'(lk_addr_i));
      chk("miss_id", 64'(miss_id), 64'(lk_id_i));
      chk("miss_set", 64'(miss_set), 64'(lk_set_i));
    end
    if (lk_valid_i && lk_hit_i) begin
      chk("rsp_data", rsp_data, lk_data_i);
      chk("rsp_error", 64'(rsp_error), 64'(lk_error_i));
    end
    chk("lk_flush_valid", 64'(lk_flush_valid), 64'(m_phase == PH_FLUSH));
    chk("flush_ready", 64'(flush_ready), 64'(m_phase == PH_DONE));
    req_hs = v && lk_ready_i;
    rsp_hs = lk_valid_i && rdy_exp;
    @(posedge clk);
    if (rst_n) begin
      if (rsp_hs && inflight.size() > 0) inflight.delete(0);
      if (req_hs) begin
        inflight.push_back(w);
        m_rr = (w + 1) % NP;
      end
      m_lock   = (v && !lk_ready_i) ? w : -1;
      last_gnt = req_hs ? w : -1;
      last_rsp = rsp_hs;
      case (m_phase)
        PH_IDLE:  if (flush_valid) m_phase = (inflight.size() == 0) ? PH_FLUSH : PH_DRAIN;
        PH_DRAIN: if (inflight.size() == 0) m_phase = PH_FLUSH;
        PH_FLUSH: if (lk_flush_ready) m_phase = PH_DONE;
        default:  m_phase = PH_IDLE;
      endcase
    end
    #1;
  endtask

  initial begin
    model_reset();
    zero_inputs();
    rst_n = 1'b0;
    #1;
    step(); step();
    rst_n = 1'b1;
    step();

    // Both ports requesting continuously: grants alternate until the in-flight limit.
    req_valid = 2'b11; req_addr[0] = 32'h100; req_addr[1] = 32'h200; lk_ready_i = 1'b1;
    repeat (4) step();
    step();

    // Miss to the refill side, then a hit held by a busy port.
    req_valid = 2'b00;
    drive_head_rsp(1'b0, 32'h340); lk_set_i = 2'd2; miss_ready = 1'b1;
    step();
    miss_ready = 1'b0;
    drive_head_rsp(1'b1, 32'h200); rsp_ready = 2'b00;
    step(); step();
    rsp_ready = 2'b10;
    step();
    lk_valid_i = 1'b0; rsp_ready = 2'b00;

    // Port 1 offered alone with no ready, then port 0 joins: grant stays locked on port 1.
    req_valid = 2'b10; lk_ready_i = 1'b0;
    step();
    req_valid = 2'b11;
    step(); step();
    lk_ready_i = 1'b1;
    step(); step();
    req_valid = 2'b00;

    // Retire two, then flush with two still in flight.
    rsp_ready = 2'b11;
    drive_head_rsp(1'b1, 32'h0); step();
    drive_head_rsp(1'b1, 32'h0); step();
    lk_valid_i = 1'b0;
    flush_valid = 1'b1; step();
    flush_valid = 1'b0; req_valid = 2'b11;
    step();
    drive_head_rsp(1'b1, 32'h0); step();
    drive_head_rsp(1'b1, 32'h0); step();
    lk_valid_i = 1'b0;
    step();
    lk_flush_ready = 1'b1; step();
    lk_flush_ready = 1'b0; step();
    step();
    req_valid = 2'b00;

    // Reset in the middle of a drain returns to idle with nothing in flight.
    flush_valid = 1'b1; step();
    flush_valid = 1'b0; step();
    zero_inputs();
    rst_n = 1'b0; step();
    rst_n = 1'b1;
    req_valid = 2'b01; req_addr[0] = 32'h480; lk_ready_i = 1'b1;
    step();
    req_valid = 2'b00; step();

    // Randomized traffic with well-behaved requesters and an in-order lookup.
    for (int n = 0; n < 600; n++) begin
      for (int p = 0; p < NP; p++) begin
        if (req_valid[p] && last_gnt == p) req_valid[p] = 1'b0;
        if (!req_valid[p] && $urandom_range(0, 99) < 60) begin
          req_valid[p] = 1'b1;
          req_addr[p]  = $urandom & 32'hFFFF_FFFC;
        end
      end
      lk_ready_i = ($urandom_range(0, 99) < 70);
      if (!(lk_valid_i && !last_rsp)) begin
        if (inflight.size() > 0 && $urandom_range(0, 1) == 1) drive_head_rsp(1'($urandom), $urandom);
        else lk_valid_i = 1'b0;
      end
      rsp_ready      = 2'($urandom);
      miss_ready     = 1'($urandom);
      flush_valid    = ($urandom_range(0, 99) < 3);
      lk_flush_ready = 1'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
